// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller:
// gate state encoding and active-low 7-segment digit patterns {g,f,e,d,c,b,a}.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        STOP          = 3'd4,
        LOCKED        = 3'd5
    } gate_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_decode
    import parking_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot entry gate: password admission, tailgate stop, lockout,
// occupancy counting and two-digit occupancy display.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int              CAPACITY    = 8,
    parameter int              PW_W        = 2,
    parameter logic [PW_W-1:0] PASS_1      = PW_W'(1),
    parameter logic [PW_W-1:0] PASS_2      = PW_W'(2),
    parameter int              MAX_TRIES   = 3,
    parameter int              TIMEOUT_CYC = 16,
    parameter int              LOCK_CYC    = 32
)(
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            sensor_entrance,
    input  logic                            sensor_exit,
    input  logic                            sensor_depart,
    input  logic [PW_W-1:0]                 password_1,
    input  logic [PW_W-1:0]                 password_2,
    input  logic                            pw_valid,
    output logic                            GREEN_LED,
    output logic                            RED_LED,
    output logic [6:0]                      HEX_1,
    output logic [6:0]                      HEX_2,
    output logic [$clog2(CAPACITY+1)-1:0]   occupancy,
    output logic                            full,
    output logic                            lockout
);

    localparam int OCC_W   = $clog2(CAPACITY + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [OCC_W-1:0] CAP_V   = OCC_W'(CAPACITY);
    localparam logic [TRY_W-1:0] TRIES_V = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] LK_LAST = TMR_W'(LOCK_CYC - 1);

    gate_state_t      state, state_nx;
    logic [TRY_W-1:0] tries, tries_nx;
    logic [TMR_W-1:0] timer;
    logic             tmr_clr;
    logic             blink;

    logic ent_q, ext_q, dep_q;
    logic ent_d, ext_d, dep_d;
    logic ent_rise, ext_rise, dep_rise;

    logic             occ_inc;
    logic [OCC_W-1:0] occ_nx;

    logic       pw_ok;
    logic       to_hit, lk_hit;
    logic [3:0] tens, units;
    logic [6:0] seg_tens, seg_units;
    int         occ_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_q <= 1'b0;
            ext_q <= 1'b0;
            dep_q <= 1'b0;
            ent_d <= 1'b0;
            ext_d <= 1'b0;
            dep_d <= 1'b0;
        end else begin
            ent_q <= sensor_entrance;
            ext_q <= sensor_exit;
            dep_q <= sensor_depart;
            ent_d <= ent_q;
            ext_d <= ext_q;
            dep_d <= dep_q;
        end
    end

    assign ent_rise = ent_q & ~ent_d;
    assign ext_rise = ext_q & ~ext_d;
    assign dep_rise = dep_q & ~dep_d;

    assign pw_ok  = (password_1 == PASS_1) && (password_2 == PASS_2);
    assign to_hit = (timer == TO_LAST);
    assign lk_hit = (timer == LK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            tries <= '0;
            blink <= 1'b0;
        end else begin
            state <= state_nx;
            tries <= tries_nx;
            blink <= ~blink;
        end
    end

    always_comb begin
        state_nx = state;
        tries_nx = tries;
        tmr_clr  = 1'b0;
        occ_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ent_rise && !full) begin
                    state_nx = WAIT_PASSWORD;
                    tries_nx = '0;
                end
            end
            WAIT_PASSWORD, WRONG_PASS, STOP: begin
                if (pw_valid) begin
                    tmr_clr = 1'b1;
                    if (pw_ok) begin
                        state_nx = RIGHT_PASS;
                    end else begin
                        tries_nx = tries + TRY_W'(1);
                        state_nx = (tries_nx == TRIES_V) ? LOCKED : WRONG_PASS;
                    end
                end else if (state != STOP && to_hit) begin
                    state_nx = IDLE;
                end
            end
            RIGHT_PASS: begin
                // Entrance still occupied at exit means a second car followed.
                if (ext_rise) begin
                    if (ent_q) begin
                        state_nx = STOP;
                    end else begin
                        occ_inc  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            LOCKED: begin
                if (lk_hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx != state) tmr_clr = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (tmr_clr) begin
            timer <= '0;
        end else if (state == WAIT_PASSWORD || state == WRONG_PASS ||
                     state == LOCKED) begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_comb begin
        occ_nx = occupancy;
        if (occ_inc && !dep_rise) begin
            if (occupancy != CAP_V) occ_nx = occupancy + OCC_W'(1);
        end else if (dep_rise && !occ_inc) begin
            if (occupancy != '0) occ_nx = occupancy - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
            full      <= 1'b0;
        end else begin
            occupancy <= occ_nx;
            full      <= (occ_nx == CAP_V);
        end
    end

    always_comb begin
        occ_i = int'(occupancy);
        tens  = 4'(occ_i / 10);
        units = 4'(occ_i % 10);
    end

    seg7_decode u_seg_tens (
        .digit (tens),
        .seg   (seg_tens)
    );

    seg7_decode u_seg_units (
        .digit (units),
        .seg   (seg_units)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HEX_1 <= SEG_0;
            HEX_2 <= SEG_0;
        end else begin
            HEX_1 <= seg_tens;
            HEX_2 <= seg_units;
        end
    end

    assign GREEN_LED = (state == RIGHT_PASS);
    assign RED_LED   = (state == WAIT_PASSWORD) || (state == LOCKED) ||
                       (((state == WRONG_PASS) || (state == STOP)) && blink);
    assign lockout   = (state == LOCKED);

endmodule
